countdown_timer: RTL and testbench
==================================

# countdown_timer

Loadable down-counting timer for the icestick LED designs: the decrementing counterpart to the free-running prescaled up-counter. A prescaler divides the clock, and each prescaler tick decrements an 8-bit count until it reaches zero. On reaching zero the timer raises a terminal-count pulse and either stops or reloads. It drives `D`-style LED buses and sequences timed events in top-level `main` designs.

## Interface
Parameters:
- `WIDTH`, default 8: width of the count, load value and reload register.
- `PRESCALE_WIDTH`, default 22: prescaler width. One tick occurs every 2^PRESCALE_WIDTH enabled cycles.

Ports:
- `CLK`, input, 1: the single clock. All state updates on the rising edge.
- `RESET`, input, 1: synchronous, active-high reset. Overrides every other input.
- `LOAD`, input, 1: one-cycle strobe. Captures `LOAD_VALUE` into both the count and the reload register.
- `LOAD_VALUE`, input, `WIDTH`: start and reload value, sampled only when `LOAD`=1.
- `CE`, input, 1: count enable. Gates the prescaler; when low, all timing is frozen.
- `AUTO_RELOAD`, input, 1: sampled on the expiry tick. 1 = restart from the reload register; 0 = stop.
- `O`, output, `WIDTH`: current count, registered.
- `TC`, output, 1: one-cycle terminal-count pulse, registered.
- `ZERO`, output, 1: high while in EXPIRED.
- `RUNNING`, output, 1: high while in RUNNING.

## Operation
- There are three states: IDLE, RUNNING and EXPIRED. The state is registered; `ZERO` and `RUNNING` decode directly from it.
- Prescaler behaviour:
  - Set to all ones on `RESET` and on `LOAD`.
  - Decrements only when `CE`=1 and state = RUNNING.
  - `tick` = RUNNING & `CE` & (prescaler == 0). On a tick the prescaler wraps to all ones.
- Priority, per cycle: `RESET` > `LOAD` > `tick`.
- RESET: state IDLE, `O`=0, reload register=0, prescaler all ones, `TC`=0.
- LOAD from any state:
  - Reload register = `LOAD_VALUE`.
  - `O` = `LOAD_VALUE`.
  - If `LOAD_VALUE` != 0, go to RUNNING; if `LOAD_VALUE` = 0, go to EXPIRED.
  - `TC` is not asserted by a load.
  - `CE` is irrelevant to a load.
- Tick in RUNNING with `O` > 1: `O` = `O` − 1, no wrap possible.
- Tick in RUNNING with `O` = 1 (expiry): `TC` = 1 on the next cycle, and then:
  - `AUTO_RELOAD`=0: `O` = 0, go to EXPIRED.
  - `AUTO_RELOAD`=1: `O` = reload register, stay in RUNNING. The prescaler wraps normally, so the period stays uniform.
- IDLE and EXPIRED hold `O` and the prescaler. Only `LOAD` or `RESET` leaves them.
- `TC` is high for exactly one cycle per expiry and low otherwise.

## Timing
- Reset values: `O`=0, `TC`=0, `ZERO`=0, `RUNNING`=0.
- Load latency: `O`, `RUNNING` and `ZERO` reflect a `LOAD` in the cycle after the strobe.
- Decrement timing: the first decrement is visible 2^PRESCALE_WIDTH enabled cycles after the load edge. Later decrements follow every 2^PRESCALE_WIDTH enabled cycles.
- Total run time with `CE` held high: a load of N ≥ 1 expires after N·2^PRESCALE_WIDTH cycles.
- At expiry, `TC`, the new `O` (0 or the reload value) and `ZERO` all change on the same edge.
- Dropping `CE` mid-period freezes both the prescaler and `O`. Raising it again resumes with no lost or extra cycles.
- `LOAD` coincident with a tick: the load wins, the prescaler restarts, and there is no `TC`.
- `LOAD` while RUNNING restarts timing from `LOAD_VALUE` (retrigger).
- `RESET` mid-count returns to IDLE on the next edge, and any pending `TC` is dropped.

## Test plan
All scenarios use `PRESCALE_WIDTH`=2 and `WIDTH`=8.
- Reset with all inputs 0: check `O`=0, `TC`=0, `ZERO`=0 and `RUNNING`=0 for 10 cycles, even with `CE`=1.
- `LOAD_VALUE`=3, `CE`=1, `AUTO_RELOAD`=0:
  - `O`=3, then 2 at +4 cycles, 1 at +8, 0 at +12.
  - `TC` is high for exactly that one cycle, with `ZERO`=1 from then on and `RUNNING`=0.
- `LOAD_VALUE`=2, `AUTO_RELOAD`=1:
  - `O` sequence is 2,1,2,1,… with 4 cycles per value.
  - `TC` pulses every 8 cycles and `ZERO` never asserts.
- `CE` gating with `LOAD_VALUE`=5: hold `CE`=0 for 7 cycles after 2 enabled cycles. `O` stays 5, then decrements exactly 2 enabled cycles after `CE` returns.
- Boundary loads:
  - `LOAD_VALUE`=0 gives `ZERO`=1 next cycle, no `TC`, and `O` stays 0.
  - `LOAD_VALUE`=255 reaches 254 after 4 cycles with no wrap.
- Simultaneous events:
  - `LOAD`=9 on a tick cycle gives `O`=9, a restarted prescaler and no `TC`.
  - `RESET` asserted together with `LOAD` and an expiring tick gives the IDLE reset values and `TC`=0.

Source files
------------

// File: rtl/countdown_timer.sv
// Loadable down-counting timer: a prescaler divides the clock and each prescaler
// tick decrements the count; reaching zero pulses TC and either stops or reloads.
module countdown_timer #(
    parameter int WIDTH          = 8,
    parameter int PRESCALE_WIDTH = 22
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_VALUE,
    input  logic             CE,
    input  logic             AUTO_RELOAD,
    output logic [WIDTH-1:0] O,
    output logic             TC,
    output logic             ZERO,
    output logic             RUNNING
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUNNING,
        ST_EXPIRED
    } state_t;

    localparam logic [PRESCALE_WIDTH-1:0] PS_ONE  = 1;
    localparam logic [WIDTH-1:0]          CNT_ONE = 1;

    state_t                    state_q;
    logic [PRESCALE_WIDTH-1:0] prescale_q;
    logic [WIDTH-1:0]          count_q;
    logic [WIDTH-1:0]          reload_q;
    logic                      tc_q;
    logic                      tick;

    assign tick = (state_q == ST_RUNNING) && CE && (prescale_q == '0);

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments only; the default
        // below is overridden later in the same block to make TC a one-cycle pulse.
        tc_q <= 1'b0;
        if (RESET) begin
            state_q    <= ST_IDLE;
            prescale_q <= '1;
            count_q    <= '0;
            reload_q   <= '0;
        end else if (LOAD) begin
            reload_q   <= LOAD_VALUE;
            count_q    <= LOAD_VALUE;
            prescale_q <= '1;
            state_q    <= (LOAD_VALUE != '0) ? ST_RUNNING : ST_EXPIRED;
        end else if ((state_q == ST_RUNNING) && CE) begin
            // Wrapping through zero restarts the period at all ones.
            prescale_q <= prescale_q - PS_ONE;
            if (tick) begin
                if (count_q > CNT_ONE) begin
                    count_q <= count_q - CNT_ONE;
                end else begin
                    tc_q <= 1'b1;
                    if (AUTO_RELOAD) begin
                        count_q <= reload_q;
                    end else begin
                        count_q <= '0;
                        state_q <= ST_EXPIRED;
                    end
                end
            end
        end
    end

    assign O       = count_q;
    assign TC      = tc_q;
    assign ZERO    = (state_q == ST_EXPIRED);
    assign RUNNING = (state_q == ST_RUNNING);

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed vector table, hand-written
// corner sequences, then random stimulus against a behavioural model.
module tb_countdown_timer;

    localparam int W      = 8;
    localparam int PW     = 2;
    localparam int PERIOD = 1 << PW;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_value = '0;
    logic         ce = 1'b0;
    logic         auto_reload = 1'b0;
    logic [W-1:0] o;
    logic         tc;
    logic         zero;
    logic         running;

    countdown_timer #(.WIDTH(W), .PRESCALE_WIDTH(PW)) dut (
        .CLK        (clk),
        .RESET      (reset),
        .LOAD       (load),
        .LOAD_VALUE (load_value),
        .CE         (ce),
        .AUTO_RELOAD(auto_reload),
        .O          (o),
        .TC         (tc),
        .ZERO       (zero),
        .RUNNING    (running)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       rst;
        bit       ld;
        bit [7:0] lv;
        bit       ce;
        bit       ar;
        int       exp_o;
        bit       exp_tc;
        bit       exp_zero;
        bit       exp_run;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference model: counts enabled cycles within the current period.
    typedef enum {M_IDLE, M_RUN, M_EXP} mmode_t;
    mmode_t m_mode = M_IDLE;
    int     m_count = 0;
    int     m_reload = 0;
    int     m_phase = 0;
    bit     m_tc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void add(bit rst, bit ld, bit [7:0] lv, bit c, bit ar,
                                int eo, bit etc, bit ez, bit er);
        vec_t v;
        v.rst = rst; v.ld = ld; v.lv = lv; v.ce = c; v.ar = ar;
        v.exp_o = eo; v.exp_tc = etc; v.exp_zero = ez; v.exp_run = er;
        vecs.push_back(v);
    endfunction

    function automatic void model_step(bit rst, bit ld, int lv, bit c, bit ar);
        m_tc = 0;
        if (rst) begin
            m_mode = M_IDLE; m_count = 0; m_reload = 0; m_phase = 0;
        end else if (ld) begin
            m_reload = lv; m_count = lv; m_phase = 0;
            m_mode = (lv != 0) ? M_RUN : M_EXP;
        end else if (m_mode == M_RUN && c) begin
            m_phase++;
            if (m_phase == PERIOD) begin
                m_phase = 0;
                if (m_count > 1) begin
                    m_count--;
                end else begin
                    m_tc = 1;
                    if (ar) m_count = m_reload;
                    else begin
                        m_count = 0; m_mode = M_EXP;
                    end
                end
            end
        end
    endfunction

    task automatic drive(bit rst, bit ld, bit [7:0] lv, bit c, bit ar);
        reset = rst; load = ld; load_value = lv; ce = c; auto_reload = ar;
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input string tag, input vec_t v);
        drive(v.rst, v.ld, v.lv, v.ce, v.ar);
        check({tag, " O"},       32'(o),       32'(v.exp_o));
        check({tag, " TC"},      32'(tc),      32'(v.exp_tc));
        check({tag, " ZERO"},    32'(zero),    32'(v.exp_zero));
        check({tag, " RUNNING"}, 32'(running), 32'(v.exp_run));
    endtask

    initial begin
        vec_t v;
        // Reset held with CE high, then IDLE ignores CE.
        for (int k = 0; k < 10; k++) add(1, 0, 8'hAA, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++)  add(0, 0, 8'hAA, 1, 0, 0, 0, 0, 0);
        // Load 3, stop at zero.
        add(0, 1, 3, 1, 0, 3, 0, 0, 1);
        for (int k = 1; k <= 16; k++)
            add(0, 0, 8'hAA, 1, 0, (k < 4) ? 3 : (k < 8) ? 2 : (k < 12) ? 1 : 0,
                k == 12, k >= 12, k < 12);
        // Load 2 with auto reload.
        add(0, 1, 2, 1, 1, 2, 0, 0, 1);
        for (int k = 1; k <= 24; k++)
            add(0, 0, 8'hAA, 1, 1, ((k / 4) % 2 == 1) ? 1 : 2, (k % 8) == 0, 0, 1);
        // CE gating with load 5.
        add(0, 1, 5, 1, 0, 5, 0, 0, 1);
        for (int k = 1; k <= 15; k++)
            add(0, 0, 8'hAA, (k < 3 || k > 9), 0, (k < 11) ? 5 : (k < 15) ? 4 : 3, 0, 0, 1);
        // Load 0 from RUNNING goes straight to EXPIRED without TC.
        add(0, 1, 0, 1, 0, 0, 0, 1, 0);
        for (int k = 0; k < 3; k++) add(0, 0, 8'hAA, 1, 1, 0, 0, 1, 0);
        // Load 255 from EXPIRED, no wrap.
        add(0, 1, 255, 1, 0, 255, 0, 0, 1);
        for (int k = 1; k <= 8; k++)
            add(0, 0, 8'hAA, 1, 0, (k < 4) ? 255 : (k < 8) ? 254 : 253, 0, 0, 1);
        // Retrigger mid-count.
        add(0, 1, 3, 1, 0, 3, 0, 0, 1);
        for (int k = 1; k <= 5; k++) add(0, 0, 8'hAA, 1, 0, (k < 4) ? 3 : 2, 0, 0, 1);
        add(0, 1, 4, 1, 0, 4, 0, 0, 1);
        for (int k = 1; k <= 4; k++) add(0, 0, 8'hAA, 1, 0, (k < 4) ? 4 : 3, 0, 0, 1);

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) apply($sformatf("vec%0d", i), vecs[i]);

        // LOAD coincident with the expiring tick: load wins, no TC, period restarts.
        drive(0, 1, 1, 1, 0);
        for (int k = 0; k < 3; k++) drive(0, 0, 0, 1, 0);
        check("pre-tick O", 32'(o), 1);
        drive(0, 1, 9, 1, 0);
        check("load-on-tick O", 32'(o), 9);
        check("load-on-tick TC", 32'(tc), 0);
        check("load-on-tick RUNNING", 32'(running), 1);
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 1, 0);
            check("restart hold O", 32'(o), 9);
            check("restart hold TC", 32'(tc), 0);
        end
        drive(0, 0, 0, 1, 0);
        check("restart first dec O", 32'(o), 8);

        // RESET with LOAD on an expiring tick: reset values, no TC.
        drive(0, 1, 1, 1, 1);
        for (int k = 0; k < 3; k++) drive(0, 0, 0, 1, 1);
        drive(1, 1, 7, 1, 1);
        check("rst+load+tick O", 32'(o), 0);
        check("rst+load+tick TC", 32'(tc), 0);
        check("rst+load+tick ZERO", 32'(zero), 0);
        check("rst+load+tick RUNNING", 32'(running), 0);
        drive(0, 0, 0, 1, 1);
        check("after rst TC", 32'(tc), 0);
        check("after rst O", 32'(o), 0);

        // Random stimulus against the model.
        drive(1, 0, 0, 0, 0);
        model_step(1, 0, 0, 0, 0);
        for (int n = 0; n < 2000; n++) begin
            v.rst = ($urandom_range(0, 99) == 0);
            v.ld  = ($urandom_range(0, 19) == 0);
            v.lv  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                : 8'($urandom_range(0, 3));
            v.ce  = ($urandom_range(0, 3) != 0);
            v.ar  = $urandom_range(0, 1) == 1;
            model_step(v.rst, v.ld, int'(v.lv), v.ce, v.ar);
            v.exp_o    = m_count;
            v.exp_tc   = m_tc;
            v.exp_zero = (m_mode == M_EXP);
            v.exp_run  = (m_mode == M_RUN);
            apply($sformatf("rand%0d", n), v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
